// File: rtl/alu_share_arb.sv
// Two-port arbiter sharing one integer ALU, with one registered response slot per requester.
// Optional per-port grant and conflict counters are built when ALU_SHARE_ARB_STATS_EN is defined.
module alu_share_arb #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned OP_W      = 4,
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [OP_W-1:0]   r0_op,
    input  logic [DATA_W-1:0] r0_in1,
    input  logic [DATA_W-1:0] r0_in2,
    output logic              r0_rsp_valid,
    input  logic              r0_rsp_ready,
    output logic [DATA_W-1:0] r0_rsp_data,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [OP_W-1:0]   r1_op,
    input  logic [DATA_W-1:0] r1_in1,
    input  logic [DATA_W-1:0] r1_in2,
    output logic              r1_rsp_valid,
    input  logic              r1_rsp_ready,
    output logic [DATA_W-1:0] r1_rsp_data,

`ifdef ALU_SHARE_ARB_STATS_EN
    output logic [31:0]       stat_grant0,
    output logic [31:0]       stat_grant1,
    output logic [31:0]       stat_conflict,
`endif

    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_out
);

    logic [1:0]        elig;
    logic [1:0]        grant;
    logic [1:0]        accept;
    logic              last_grant;
    logic [1:0]        slot_valid;
    logic [DATA_W-1:0] slot_data0;
    logic [DATA_W-1:0] slot_data1;

    assign r0_rsp_valid = slot_valid[0];
    assign r1_rsp_valid = slot_valid[1];
    assign r0_rsp_data  = slot_data0;
    assign r1_rsp_data  = slot_data1;
    assign r0_ready     = accept[0];
    assign r1_ready     = accept[1];

    // A port may compete only if its slot is empty or emptying this cycle.
    always_comb begin
        elig[0] = r0_valid && (!slot_valid[0] || r0_rsp_ready);
        elig[1] = r1_valid && (!slot_valid[1] || r1_rsp_ready);
    end

    always_comb begin
        grant = 2'b00;
        if (elig == 2'b11) begin
            if ((PRIO_MODE != 0) || last_grant) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end else begin
            grant = elig;
        end
        accept = grant & {2{!rst}};
    end

    // Winner's request drives the ALU; idle cycles present zeros.
    always_comb begin
        alu_op  = '0;
        alu_in1 = '0;
        alu_in2 = '0;
        if (grant[0]) begin
            alu_op  = r0_op;
            alu_in1 = r0_in1;
            alu_in2 = r0_in2;
        end else if (grant[1]) begin
            alu_op  = r1_op;
            alu_in1 = r1_in1;
            alu_in2 = r1_in2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            slot_valid <= 2'b00;
            slot_data0 <= '0;
            slot_data1 <= '0;
        end else begin
            if (grant != 2'b00) begin
                last_grant <= grant[1];
            end

            // A new result overrides a drain in the same cycle.
            if (accept[0]) begin
                slot_valid[0] <= 1'b1;
                slot_data0    <= alu_out;
            end else if (slot_valid[0] && r0_rsp_ready) begin
                slot_valid[0] <= 1'b0;
            end

            if (accept[1]) begin
                slot_valid[1] <= 1'b1;
                slot_data1    <= alu_out;
            end else if (slot_valid[1] && r1_rsp_ready) begin
                slot_valid[1] <= 1'b0;
            end
        end
    end

`ifdef ALU_SHARE_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grant0   <= '0;
            stat_grant1   <= '0;
            stat_conflict <= '0;
        end else begin
            if (accept[0]) begin
                stat_grant0 <= stat_grant0 + 32'd1;
            end
            if (accept[1]) begin
                stat_grant1 <= stat_grant1 + 32'd1;
            end
            if (elig == 2'b11) begin
                stat_conflict <= stat_conflict + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: a round-robin and a fixed-priority instance share stimulus and are
// each compared every cycle against a transaction-level model; stats checked when ALU_SHARE_ARB_STATS_EN is set.
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, rr0, rr1;
    logic [3:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;

    logic        rdy0 [2];
    logic        rdy1 [2];
    logic        rv0  [2];
    logic        rv1  [2];
    logic [31:0] rd0  [2];
    logic [31:0] rd1  [2];
    logic [3:0]  aop  [2];
    logic [31:0] ai1  [2];
    logic [31:0] ai2  [2];
    logic [31:0] ao   [2];
`ifdef ALU_SHARE_ARB_STATS_EN
    logic [31:0] sg0  [2];
    logic [31:0] sg1  [2];
    logic [31:0] scf  [2];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level expectation per instance (0 = round-robin, 1 = fixed priority).
    logic        m_rv   [2][2];
    logic [31:0] m_rd   [2][2];
    int          m_last [2];
    int unsigned m_g    [2][2];
    int unsigned m_cf   [2];

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x & y;
            4'd3:    return x | y;
            4'd4:    return x ^ y;
            4'd5:    return x << y[4:0];
            default: return 32'h0;
        endcase
    endfunction

    assign ao[0] = alu_fn(aop[0], ai1[0], ai2[0]);
    assign ao[1] = alu_fn(aop[1], ai1[1], ai2[1]);

    alu_share_arb #(.DATA_W(32), .OP_W(4), .PRIO_MODE(0)) u_rr (
        .clk(clk), .rst(rst),
        .r0_valid(v0), .r0_ready(rdy0[0]), .r0_op(op0), .r0_in1(a0), .r0_in2(b0),
        .r0_rsp_valid(rv0[0]), .r0_rsp_ready(rr0), .r0_rsp_data(rd0[0]),
        .r1_valid(v1), .r1_ready(rdy1[0]), .r1_op(op1), .r1_in1(a1), .r1_in2(b1),
        .r1_rsp_valid(rv1[0]), .r1_rsp_ready(rr1), .r1_rsp_data(rd1[0]),
`ifdef ALU_SHARE_ARB_STATS_EN
        .stat_grant0(sg0[0]), .stat_grant1(sg1[0]), .stat_conflict(scf[0]),
`endif
        .alu_op(aop[0]), .alu_in1(ai1[0]), .alu_in2(ai2[0]), .alu_out(ao[0])
    );

    alu_share_arb #(.DATA_W(32), .OP_W(4), .PRIO_MODE(1)) u_fp (
        .clk(clk), .rst(rst),
        .r0_valid(v0), .r0_ready(rdy0[1]), .r0_op(op0), .r0_in1(a0), .r0_in2(b0),
        .r0_rsp_valid(rv0[1]), .r0_rsp_ready(rr0), .r0_rsp_data(rd0[1]),
        .r1_valid(v1), .r1_ready(rdy1[1]), .r1_op(op1), .r1_in1(a1), .r1_in2(b1),
        .r1_rsp_valid(rv1[1]), .r1_rsp_ready(rr1), .r1_rsp_data(rd1[1]),
`ifdef ALU_SHARE_ARB_STATS_EN
        .stat_grant0(sg0[1]), .stat_grant1(sg1[1]), .stat_conflict(scf[1]),
`endif
        .alu_op(aop[1]), .alu_in1(ai1[1]), .alu_in2(ai2[1]), .alu_out(ao[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_last[m] = 1;
            m_cf[m]   = 0;
            for (int p = 0; p < 2; p++) begin
                m_rv[m][p] = 1'b0;
                m_rd[m][p] = 32'h0;
                m_g[m][p]  = 0;
            end
        end
    endtask

    // Compare one instance with the model for the current cycle, then advance the model.
    task automatic model_cycle(input int m);
        logic        e0, e1;
        int          win;
        logic [3:0]  xop;
        logic [31:0] x1, x2;
        string       p;
        p   = (m == 0) ? "rr" : "fp";
        e0  = v0 && (!m_rv[m][0] || rr0);
        e1  = v1 && (!m_rv[m][1] || rr1);
        if (e0 && e1)  win = (m == 1) ? 0 : 1 - m_last[m];
        else if (e0)   win = 0;
        else if (e1)   win = 1;
        else           win = -1;

        chk({p, ".r0_ready"}, 32'(rdy0[m]), 32'(win == 0 && !rst));
        chk({p, ".r1_ready"}, 32'(rdy1[m]), 32'(win == 1 && !rst));
        if (!rst) begin
            xop = (win == 0) ? op0 : (win == 1) ? op1 : 4'h0;
            x1  = (win == 0) ? a0  : (win == 1) ? a1  : 32'h0;
            x2  = (win == 0) ? b0  : (win == 1) ? b1  : 32'h0;
            chk({p, ".alu_op"},  32'(aop[m]), 32'(xop));
            chk({p, ".alu_in1"}, ai1[m], x1);
            chk({p, ".alu_in2"}, ai2[m], x2);
        end
        chk({p, ".r0_rsp_valid"}, 32'(rv0[m]), 32'(m_rv[m][0]));
        chk({p, ".r1_rsp_valid"}, 32'(rv1[m]), 32'(m_rv[m][1]));
        chk({p, ".r0_rsp_data"},  rd0[m], m_rd[m][0]);
        chk({p, ".r1_rsp_data"},  rd1[m], m_rd[m][1]);
`ifdef ALU_SHARE_ARB_STATS_EN
        chk({p, ".stat_grant0"},   sg0[m], m_g[m][0]);
        chk({p, ".stat_grant1"},   sg1[m], m_g[m][1]);
        chk({p, ".stat_conflict"}, scf[m], m_cf[m]);
`endif

        if (rst) begin
            m_last[m] = 1;
            m_cf[m]   = 0;
            for (int i = 0; i < 2; i++) begin
                m_rv[m][i] = 1'b0;
                m_rd[m][i] = 32'h0;
                m_g[m][i]  = 0;
            end
        end else begin
            if (win == 0) begin
                m_rv[m][0] = 1'b1;
                m_rd[m][0] = alu_fn(op0, a0, b0);
            end else if (m_rv[m][0] && rr0) begin
                m_rv[m][0] = 1'b0;
            end
            if (win == 1) begin
                m_rv[m][1] = 1'b1;
                m_rd[m][1] = alu_fn(op1, a1, b1);
            end else if (m_rv[m][1] && rr1) begin
                m_rv[m][1] = 1'b0;
            end
            if (win >= 0) begin
                m_last[m] = win;
                m_g[m][win]++;
            end
            if (e0 && e1) m_cf[m]++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_cycle(0);
        model_cycle(1);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        v0 = 1'b0; v1 = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
        op0 = 4'h0; op1 = 4'h0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); nxt();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();

        // Reset state, with a request pending that must not be accepted.
        v0 = 1'b1;
        tick();
        chk("rst.r0_ready", 32'(rdy0[0]), 32'd0);
        nxt();
        do_reset();

        // Single ADD on port 0.
        v0 = 1'b1; op0 = 4'd0; a0 = 32'd5; b0 = 32'd7;
        tick();
        chk("single.r0_ready", 32'(rdy0[0]), 32'd1);
        chk("single.alu_in1",  ai1[0], 32'd5);
        nxt();
        v0 = 1'b0;
        tick();
        chk("single.rsp_valid_n1", 32'(rv0[0]), 32'd1);
        chk("single.rsp_data_n1",  rd0[0], 32'd12);
        nxt();
        tick();
        chk("single.rsp_valid_n2", 32'(rv0[0]), 32'd0);
        nxt();

        // Ties: alternate under round-robin, port 0 always under fixed priority.
        do_reset();
        v0 = 1'b1; op0 = 4'd1; a0 = 32'd10;   b0 = 32'd3;
        v1 = 1'b1; op1 = 4'd4; a1 = 32'hF0;   b1 = 32'h0F;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("tie.rr.r0_ready[%0d]", k), 32'(rdy0[0]), 32'(k % 2 == 0));
            chk($sformatf("tie.rr.r1_ready[%0d]", k), 32'(rdy1[0]), 32'(k % 2 == 1));
            chk($sformatf("tie.fp.r0_ready[%0d]", k), 32'(rdy0[1]), 32'd1);
            chk($sformatf("tie.fp.r1_ready[%0d]", k), 32'(rdy1[1]), 32'd0);
            if (k % 2 == 1) chk($sformatf("tie.rr.r0_data[%0d]", k), rd0[0], 32'd7);
            if (k >= 2 && k % 2 == 0) chk($sformatf("tie.rr.r1_data[%0d]", k), rd1[0], 32'hFF);
            nxt();
        end
        v0 = 1'b0;
        tick();
        chk("tie.fp.r1_after_drop", 32'(rdy1[1]), 32'd1);
        nxt();

        // Backpressure on port 0 lets port 1 take every cycle.
        do_reset();
        v0 = 1'b1; op0 = 4'd0; a0 = 32'd1; b0 = 32'd2;
        tick(); nxt();
        rr0 = 1'b0;
        v1 = 1'b1; op1 = 4'd3; a1 = 32'h100; b1 = 32'h011;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp.r0_ready[%0d]", k), 32'(rdy0[0]), 32'd0);
            chk($sformatf("bp.r1_ready[%0d]", k), 32'(rdy1[0]), 32'd1);
            nxt();
        end
        rr0 = 1'b1;
        tick();
        chk("bp.rr.r0_ready_release", 32'(rdy0[0]), 32'd1);
        chk("bp.fp.r0_ready_release", 32'(rdy0[1]), 32'd1);
        nxt();
        v0 = 1'b0; v1 = 1'b0;
        tick();
        chk("bp.r0_rsp_stays_valid", 32'(rv0[0]), 32'd1);
        chk("bp.r0_rsp_data",        rd0[0], 32'd3);
        nxt();

        // Reset in the cycle the result appears.
        do_reset();
        v1 = 1'b1; op1 = 4'd2; a1 = 32'hFF; b1 = 32'h0F;
        tick();
        chk("rstmid.r1_ready", 32'(rdy1[0]), 32'd1);
        nxt();
        v1 = 1'b0; rr1 = 1'b0; rst = 1'b1;
        tick();
        chk("rstmid.r1_rsp_data_n1", rd1[0], 32'h0F);
        nxt();
        rst = 1'b0;
        tick();
        chk("rstmid.r1_rsp_valid", 32'(rv1[0]), 32'd0);
        chk("rstmid.r1_rsp_data",  rd1[0], 32'd0);
        nxt();
        rr1 = 1'b1; v0 = 1'b1; v1 = 1'b1;
        tick();
        chk("rstmid.first_tie_r0", 32'(rdy0[0]), 32'd1);
        nxt();

        // Three ties then two port-0-only requests.
        do_reset();
        v0 = 1'b1; v1 = 1'b1;
        for (int k = 0; k < 3; k++) begin tick(); nxt(); end
        v1 = 1'b0;
        for (int k = 0; k < 2; k++) begin tick(); nxt(); end
        v0 = 1'b0;
        tick();
`ifdef ALU_SHARE_ARB_STATS_EN
        chk("stats.rr.grant0",   sg0[0], 32'd4);
        chk("stats.rr.grant1",   sg1[0], 32'd1);
        chk("stats.rr.conflict", scf[0], 32'd3);
        chk("stats.fp.grant0",   sg0[1], 32'd5);
        chk("stats.fp.grant1",   sg1[1], 32'd0);
        chk("stats.fp.conflict", scf[1], 32'd3);
`endif
        nxt();

        // Random traffic with occasional reset.
        for (int k = 0; k < 400; k++) begin
            v0  = ($urandom_range(0, 3) != 0);
            v1  = ($urandom_range(0, 3) != 0);
            rr0 = ($urandom_range(0, 9) < 7);
            rr1 = ($urandom_range(0, 9) < 7);
            op0 = 4'($urandom_range(0, 6));
            op1 = 4'($urandom_range(0, 6));
            a0  = $urandom; b0 = $urandom;
            a1  = $urandom; b1 = $urandom;
            rst = ($urandom_range(0, 49) == 0);
            tick();
            nxt();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Arbitrates the single integer ALU between two requesters: port 0, the pipeline EX stage, and port 1, an auxiliary unit such as a CSR or address-gen helper.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block muxes the winner's op/operands onto the ALU and registers the ALU result into a per-requester response slot.
- The result is returned one cycle after acceptance.

Parameters:
- DATA_W, 32, operand/result width.
- OP_W, 4, ALU op-code width; op codes pass through unmodified.
- PRIO_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 0 always wins.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- r0_valid  in  1  port-0 request valid.
- r0_ready  out  1  port-0 request accepted this cycle when high with r0_valid.
- r0_op  in  OP_W  port-0 ALU op.
- r0_in1  in  DATA_W  port-0 operand 1.
- r0_in2  in  DATA_W  port-0 operand 2.
- r0_rsp_valid  out  1  port-0 result available.
- r0_rsp_ready  in  1  port-0 consumer takes result.
- r0_rsp_data  out  DATA_W  port-0 result.
- r1_valid, r1_ready, r1_op, r1_in1, r1_in2, r1_rsp_valid, r1_rsp_ready, r1_rsp_data: same as port 0, for port 1.
- alu_op  out  OP_W  to ALU.
- alu_in1  out  DATA_W  to ALU.
- alu_in2  out  DATA_W  to ALU.
- alu_out  in  DATA_W  ALU combinational result.

Behaviour:
- Eligibility:
  - slot_free[i] = !ri_rsp_valid || ri_rsp_ready.
  - elig[i] = ri_valid && slot_free[i].
- Grant is combinational, at most one port per cycle.
  - Round-robin (PRIO_MODE=0): when both ports are eligible, grant the port not granted most recently. Otherwise grant the single eligible port.
  - The last-grant pointer updates only on an actual grant. After reset it points at port 1, so port 0 wins the first tie.
  - Fixed priority (PRIO_MODE=1): port 0 wins any tie; the pointer is unused.
- ri_ready = grant[i] && !rst. Acceptance = ri_valid && ri_ready.
- ALU drive:
  - Granted: alu_op/alu_in1/alu_in2 = winner's op/in1/in2.
  - No grant: all ALU inputs driven to 0.
- Latency: request accepted in cycle N → ri_rsp_valid=1 and ri_rsp_data=alu_out(cycle N) in cycle N+1.
- Response slot i:
  - On accept: rsp_valid←1, rsp_data←alu_out.
  - Else if rsp_valid && rsp_ready: rsp_valid←0, and rsp_data holds its last value.
  - Simultaneous drain and new accept on the same port in one cycle: the new result is loaded and rsp_valid stays 1. This gives full throughput of 1 op/cycle per port when the consumer is always ready.
- Backpressure:
  - A port whose slot is full and not draining is never granted.
  - The other port may use the ALU in that cycle; no bubble is forced.
- Requester rule: op/in1/in2 must stay stable while ri_valid=1 and ri_ready=0. The block does not latch requests.
- Responder rule: rsp_valid/rsp_data stay stable until rsp_ready.
- Reset, including mid-operation: next cycle all rsp_valid=0, rsp_data=0, pointer=port 1, counters=0. Pending results are discarded. ready=0 while rst=1.
- No internal state other than the 2 response slots, the pointer and the optional counters.

Optional Feature:
- Macro: ALU_SHARE_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_grant0 and stat_grant1 (32 bits) counting accepted requests per port.
  - Adds output stat_conflict (32 bits) counting cycles where both elig bits are 1.
  - All counters wrap modulo 2^32 and are cleared by rst.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Single op: r0 op=ADD, in1=5, in2=7, r0_rsp_ready=1 → r0_ready=1 in cycle N; alu_in1=5; r0_rsp_valid=1 with data 12 in N+1, then 0 in N+2.
- Tie, round-robin: both ports valid for 4 cycles, port 0 SUB 10-3, port 1 XOR 0xF0^0x0F, both consumers ready → grants 0,1,0,1; responses 7 and 0xFF alternate one cycle after each grant.
- Backpressure: r0_rsp_ready=0 with slot 0 full, r0_valid=1, r1_valid=1 → r0_ready=0, r1 granted every cycle. Raise r0_rsp_ready → r0 granted that same cycle, slot reloads, r0_rsp_valid stays 1.
- Fixed priority (PRIO_MODE=1): both ports valid for 3 cycles → port 0 granted all 3, r1_ready=0. Port 1 is granted the first cycle r0_valid drops.
- Reset mid-op: accept r1 AND 0xFF&0x0F, assert rst in N+1 → r1_rsp_valid=0 and data=0 after reset. The first tie after reset goes to port 0.
- Stats (ALU_SHARE_ARB_STATS_EN): 3 ties plus 2 r0-only accepts → stat_grant0=4 (2 of 3 ties plus 2 r0-only), stat_grant1=1 (1 of 3 ties), stat_conflict=3.
